// File: rtl/prirv32_core_sequencer_pkg.sv
// prirv32_pkg: shared definitions for the priRV32 core sequencer.
//   - FSM state encoding (also exported on state_o for debug)
//   - bit positions in the decoder's 47-bit one-hot instruction-set vector
//   - instruction class masks used by the sequencer
//   - trap cause codes
package prirv32_pkg;

    localparam int unsigned ISET_W = 47;
    typedef logic [ISET_W-1:0] iset_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } seq_state_e;

    localparam int unsigned IDX_LUI    = 46;
    localparam int unsigned IDX_AUIPC  = 45;
    localparam int unsigned IDX_JAL    = 44;
    localparam int unsigned IDX_JALR   = 43;
    localparam int unsigned IDX_BEQ    = 42;
    localparam int unsigned IDX_BNE    = 41;
    localparam int unsigned IDX_BLT    = 40;
    localparam int unsigned IDX_BGE    = 39;
    localparam int unsigned IDX_BLTU   = 38;
    localparam int unsigned IDX_BGEU   = 37;
    localparam int unsigned IDX_LB     = 36;
    localparam int unsigned IDX_LH     = 35;
    localparam int unsigned IDX_LW     = 34;
    localparam int unsigned IDX_LBU    = 33;
    localparam int unsigned IDX_LHU    = 32;
    localparam int unsigned IDX_SB     = 31;
    localparam int unsigned IDX_SH     = 30;
    localparam int unsigned IDX_SW     = 29;
    localparam int unsigned IDX_ADDI   = 28;
    localparam int unsigned IDX_SLTI   = 27;
    localparam int unsigned IDX_SLTIU  = 26;
    localparam int unsigned IDX_XORI   = 25;
    localparam int unsigned IDX_ORI    = 24;
    localparam int unsigned IDX_ANDI   = 23;
    localparam int unsigned IDX_SLLI   = 22;
    localparam int unsigned IDX_SRLI   = 21;
    localparam int unsigned IDX_SRAI   = 20;
    localparam int unsigned IDX_ADD    = 19;
    localparam int unsigned IDX_SUB    = 18;
    localparam int unsigned IDX_SLL    = 17;
    localparam int unsigned IDX_SLT    = 16;
    localparam int unsigned IDX_SLTU   = 15;
    localparam int unsigned IDX_XOR    = 14;
    localparam int unsigned IDX_SRL    = 13;
    localparam int unsigned IDX_SRA    = 12;
    localparam int unsigned IDX_OR     = 11;
    localparam int unsigned IDX_AND    = 10;
    localparam int unsigned IDX_FENCE  = 9;
    localparam int unsigned IDX_FENCEI = 8;
    localparam int unsigned IDX_ECALL  = 7;
    localparam int unsigned IDX_EBREAK = 6;
    localparam int unsigned IDX_CSRRW  = 5;
    localparam int unsigned IDX_CSRRS  = 4;
    localparam int unsigned IDX_CSRRC  = 3;
    localparam int unsigned IDX_CSRRWI = 2;
    localparam int unsigned IDX_CSRRSI = 1;
    localparam int unsigned IDX_CSRRCI = 0;

    // Contiguous run of ones from bit lo up to bit hi.
    function automatic iset_t bit_range(input int unsigned hi, input int unsigned lo);
        iset_t m;
        m = '0;
        for (int unsigned i = lo; i <= hi; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam iset_t LOAD_MASK   = bit_range(IDX_LB, IDX_LHU);
    localparam iset_t STORE_MASK  = bit_range(IDX_SB, IDX_SW);
    localparam iset_t BRANCH_MASK = bit_range(IDX_BEQ, IDX_BGEU);
    localparam iset_t NO_WB_MASK  = BRANCH_MASK | STORE_MASK
                                  | bit_range(IDX_FENCE, IDX_FENCEI);

    localparam logic [1:0] CAUSE_ILLEGAL     = 2'd0;
    localparam logic [1:0] CAUSE_ECALL       = 2'd1;
    localparam logic [1:0] CAUSE_EBREAK      = 2'd2;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd3;

endpackage

// File: rtl/prirv32_core_sequencer_if.sv
// prirv32_core_sequencer_if: single shared memory port of the priRV32 core.
//   mem_req_o   request, held until mem_ready_i
//   mem_we_o    1 = store, 0 = read
//   mem_addr_o  byte address
//   mem_ready_i request completes this cycle
//   mem_rdata_i read data, valid with mem_ready_i
// master = core side (sequencer), slave = memory side.
interface prirv32_core_sequencer_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        input  mem_ready_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        output mem_ready_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/prirv32_core_sequencer_onehot_check.sv
// prirv32_onehot_check: combinational exactly-one-hot detector for the
// decoder's 47-bit instruction-set vector.
//   vec_i     instruction-set vector
//   onehot_o  1 when exactly one bit of vec_i is set
module prirv32_onehot_check
    import prirv32_pkg::*;
(
    input  iset_t vec_i,
    output logic  onehot_o
);
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - iset_t'(1))) == '0);
endmodule

// File: rtl/prirv32_core_sequencer.sv
// prirv32_core_sequencer: multi-cycle control FSM of the priRV32 core.
// Sequences fetch, decode latch, execute, data memory access and writeback,
// shares the one memory port between fetch and load/store, owns the PC and
// raises traps (illegal, ecall, ebreak, memory timeout).
//
// Ports:
//   clk_i, rst_n           clock; synchronous active-low reset
//   mem                    shared memory port (master modport)
//   instr_o                latched instruction word, to the decoder
//   instrset_i             decoder one-hot output for instr_o
//   exu_addr_i, next_pc_i  EXU load/store address and next PC
//   pc_o                   architectural PC, to the EXU
//   instrset_latched_o     registered instrset_i, to the EXU
//   exu_en_o, rd_we_o      one-cycle execute / register write strobes
//   trap_o, trap_cause_o   one-cycle trap pulse; cause held until next trap
//   state_o                current FSM state (debug)
//
// Optional: define PRIRV32_SEQ_TIMEOUT_EN to trap (cause 3) when a memory
// request waits MEM_TIMEOUT cycles without mem_ready_i.
//
// state  | meaning
// FETCH  | request instruction at pc; latch word on ready
// DECODE | latch instruction set; detect illegal / ecall / ebreak
// EXEC   | execute strobe; choose memory access or writeback
// MEM    | load/store at exu_addr_i until ready
// WB     | register write strobe (by class); pc <= next_pc_i
// TRAP   | trap pulse; pc <= TRAP_VEC
module prirv32_core_sequencer
    import prirv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0010,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    prirv32_core_sequencer_if.master       mem,
    output logic [31:0]                    instr_o,
    input  logic [ISET_W-1:0]              instrset_i,
    input  logic [31:0]                    exu_addr_i,
    input  logic [31:0]                    next_pc_i,
    output logic [31:0]                    pc_o,
    output logic [ISET_W-1:0]              instrset_latched_o,
    output logic                           exu_en_o,
    output logic                           rd_we_o,
    output logic                           trap_o,
    output logic [1:0]                     trap_cause_o,
    output logic [2:0]                     state_o
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    iset_t       iset_q;
    logic [1:0]  cause_q, cause_d;

    logic        is_onehot;
    logic        in_wait;
    logic        mem_timeout;

    logic        req_c, we_c, exu_en_c, rd_we_c, trap_c;
    logic [31:0] addr_c;

    prirv32_onehot_check u_onehot (
        .vec_i    (instrset_i),
        .onehot_o (is_onehot)
    );

    assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);

`ifdef PRIRV32_SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
    logic [7:0] wait_cnt_q;

    // FETCH and MEM are only ever entered from other states, so clearing
    // outside them leaves the counter at zero on every entry.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
        end else if (in_wait && !mem.mem_ready_i) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_q <= 8'd0;
        end
    end

    // Fires on the cycle whose increment would reach the limit; a ready
    // in that same cycle takes priority.
    assign mem_timeout = in_wait && !mem.mem_ready_i
                       && ((wait_cnt_q + 8'd1) == TIMEOUT_CNT);
`else
    logic [31:0] unused_mem_timeout;
    assign unused_mem_timeout = 32'(MEM_TIMEOUT);
    assign mem_timeout        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = 32'd0;
        exu_en_c = 1'b0;
        rd_we_c  = 1'b0;
        trap_c   = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem.mem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (mem_timeout) begin
                    cause_d = CAUSE_MEM_TIMEOUT;
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (!is_onehot) begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = ST_TRAP;
                end else if (instrset_i[IDX_ECALL]) begin
                    cause_d = CAUSE_ECALL;
                    state_d = ST_TRAP;
                end else if (instrset_i[IDX_EBREAK]) begin
                    cause_d = CAUSE_EBREAK;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exu_en_c = 1'b1;
                if ((iset_q & (LOAD_MASK | STORE_MASK)) != '0) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                req_c  = 1'b1;
                addr_c = exu_addr_i;
                we_c   = (iset_q & STORE_MASK) != '0;
                if (mem.mem_ready_i) begin
                    state_d = ST_WB;
                end else if (mem_timeout) begin
                    cause_d = CAUSE_MEM_TIMEOUT;
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                rd_we_c = (iset_q & NO_WB_MASK) == '0;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trap_c  = 1'b1;
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Strobes stay quiet while reset is held, even though the state
        // register already reads FETCH.
        if (!rst_n) begin
            req_c    = 1'b0;
            we_c     = 1'b0;
            addr_c   = 32'd0;
            exu_en_c = 1'b0;
            rd_we_c  = 1'b0;
            trap_c   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            iset_q  <= '0;
            cause_q <= CAUSE_ILLEGAL;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if ((state_q == ST_FETCH) && mem.mem_ready_i) begin
                instr_q <= mem.mem_rdata_i;
            end
            if (state_q == ST_DECODE) begin
                iset_q <= instrset_i;
            end
            if (state_q == ST_WB) begin
                pc_q <= next_pc_i;
            end else if (state_q == ST_TRAP) begin
                pc_q <= TRAP_VEC;
            end
        end
    end

    assign mem.mem_req_o      = req_c;
    assign mem.mem_we_o       = we_c;
    assign mem.mem_addr_o     = addr_c;
    assign instr_o            = instr_q;
    assign pc_o               = pc_q;
    assign instrset_latched_o = iset_q;
    assign exu_en_o           = exu_en_c;
    assign rd_we_o            = rd_we_c;
    assign trap_o             = trap_c;
    assign trap_cause_o       = cause_q;
    assign state_o            = state_q;

endmodule
